if_fetch_stage: RTL and testbench



---
 rtl/if_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 35 +++
 rtl/if_fetch_stage.sv | 159 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

  // IF_inJUMP: 10/11 are reserved and behave like JUMP_NONE
  localparam logic [1:0] JUMP_NONE  = 2'b00;
  localparam logic [1:0] JUMP_J     = 2'b01;
  localparam logic [1:0] RJUMP_NONE = 2'b00;

  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: redirect target priority mux and the PC+4 adder.
module pc_next_sel
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pcsrc,
  input  logic [31:0] baddress,
  input  logic [1:0]  jump,
  input  logic [31:0] jumpaddress,
  input  logic [1:0]  rjump,
  input  logic [31:0] jraddress,
  output logic [31:0] pc_add4,
  output logic [31:0] target,
  output logic        redir_req
);

  assign pc_add4 = pc + 32'd4;

  // Register jumps outrank direct jumps, which outrank conditional branches.
  always_comb begin
    target    = baddress;
    redir_req = 1'b0;
    if (rjump != RJUMP_NONE) begin
      target    = jraddress;
      redir_req = 1'b1;
    end else if (jump == JUMP_J) begin
      target    = jumpaddress;
      redir_req = 1'b1;
    end else if (pcsrc) begin
      target    = baddress;
      redir_req = 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, ready-handshake imem port and redirect handling.
// Build option: define IF_FLUSH_EN to squash the word fetched in a redirect cycle (no delay slot).
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IF_inPCWRITE,
  input  logic        IF_inIFIDWRITE,
  input  logic        IF_inPCSRC,
  input  logic [31:0] IF_inBADDRESS,
  input  logic [1:0]  IF_inJUMP,
  input  logic [31:0] IF_inJUMPADDRESS,
  input  logic [1:0]  IF_inRJUMP,
  input  logic [31:0] IF_inJRADDRESS,
  output logic        IF_outIMEMREQ,
  output logic [31:0] IF_outIMEMADDR,
  input  logic        IF_inIMEMREADY,
  input  logic [31:0] IF_inIMEMDATA,
  output logic [31:0] IFID_ORDER,
  output logic [31:0] IFID_PCADD4,
  output logic        IF_outBUSY
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  skid, skid_n;
  logic [31:0]  pend, pend_n;
  logic         pend_hold, pend_hold_n;
  logic [31:0]  order_n, pcadd4_n;
  logic [31:0]  pc_add4, target;
  logic         redir_req, adv, redir;

  pc_next_sel u_pc_next_sel (
    .pc          (pc),
    .pcsrc       (IF_inPCSRC),
    .baddress    (IF_inBADDRESS),
    .jump        (IF_inJUMP),
    .jumpaddress (IF_inJUMPADDRESS),
    .rjump       (IF_inRJUMP),
    .jraddress   (IF_inJRADDRESS),
    .pc_add4     (pc_add4),
    .target      (target),
    .redir_req   (redir_req)
  );

  assign adv   = IF_inPCWRITE & IF_inIFIDWRITE;
  assign redir = adv & redir_req;

  // Request drops asynchronously with RESET so an in-flight fetch is abandoned at once.
  assign IF_outIMEMREQ  = ~RESET & (state != HOLD);
  assign IF_outIMEMADDR = pc;
  assign IF_outBUSY     = (state != FETCH);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    skid_n      = skid;
    pend_n      = pend;
    pend_hold_n = pend_hold;
    order_n     = IFID_ORDER;
    pcadd4_n    = IFID_PCADD4;
    case (state)
      FETCH: begin
        if (IF_inIMEMREADY) begin
          if (adv) begin
            pc_n     = redir ? target : pc_add4;
            order_n  = IF_inIMEMDATA;
            pcadd4_n = pc_add4;
`ifdef IF_FLUSH_EN
            if (redir) begin
              order_n  = NOP_WORD;
              pcadd4_n = 32'd0;
            end
`endif
          end else begin
            skid_n  = IF_inIMEMDATA;
            state_n = HOLD;
          end
        end else if (redir) begin
          pend_n   = target;
          order_n  = NOP_WORD;
          pcadd4_n = 32'd0;
          state_n  = REDIR;
        end else if (adv) begin
          order_n  = NOP_WORD;
          pcadd4_n = 32'd0;
        end
      end
      HOLD: begin
        if (adv) begin
          order_n  = skid;
          pcadd4_n = pc_add4;
`ifdef IF_FLUSH_EN
          if (redir) begin
            order_n  = NOP_WORD;
            pcadd4_n = 32'd0;
          end
`endif
          // A deferred REDIR target (delay slot parked in skid) is applied on exit.
          pc_n        = redir ? target : (pend_hold ? pend : pc_add4);
          pend_hold_n = 1'b0;
          state_n     = FETCH;
        end
      end
      REDIR: begin
        if (redir) pend_n = target;
        if (IF_inIMEMREADY) begin
`ifdef IF_FLUSH_EN
          pc_n    = pend_n;
          state_n = FETCH;
`else
          if (adv) begin
            order_n  = IF_inIMEMDATA;
            pcadd4_n = pc_add4;
            pc_n     = pend_n;
            state_n  = FETCH;
          end else begin
            skid_n      = IF_inIMEMDATA;
            pend_hold_n = 1'b1;
            state_n     = HOLD;
          end
`endif
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc          <= RESET_PC;
      skid        <= 32'd0;
      pend        <= 32'd0;
      pend_hold   <= 1'b0;
      IFID_ORDER  <= NOP_WORD;
      IFID_PCADD4 <= 32'd0;
    end else begin
      pc          <= pc_n;
      skid        <= skid_n;
      pend        <= pend_n;
      pend_hold   <= pend_hold_n;
      IFID_ORDER  <= order_n;
      IFID_PCADD4 <= pcadd4_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage; memory model returns word = address.
module tb_if_fetch_stage;

`ifdef IF_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        IF_inPCWRITE = 1'b0;
  logic        IF_inIFIDWRITE = 1'b0;
  logic        IF_inPCSRC = 1'b0;
  logic [31:0] IF_inBADDRESS = 32'd0;
  logic [1:0]  IF_inJUMP = 2'b00;
  logic [31:0] IF_inJUMPADDRESS = 32'd0;
  logic [1:0]  IF_inRJUMP = 2'b00;
  logic [31:0] IF_inJRADDRESS = 32'd0;
  logic        IF_outIMEMREQ;
  logic [31:0] IF_outIMEMADDR;
  logic        IF_inIMEMREADY = 1'b0;
  logic [31:0] IF_inIMEMDATA;
  logic [31:0] IFID_ORDER;
  logic [31:0] IFID_PCADD4;
  logic        IF_outBUSY;

  if_fetch_stage dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .IF_inPCWRITE     (IF_inPCWRITE),
    .IF_inIFIDWRITE   (IF_inIFIDWRITE),
    .IF_inPCSRC       (IF_inPCSRC),
    .IF_inBADDRESS    (IF_inBADDRESS),
    .IF_inJUMP        (IF_inJUMP),
    .IF_inJUMPADDRESS (IF_inJUMPADDRESS),
    .IF_inRJUMP       (IF_inRJUMP),
    .IF_inJRADDRESS   (IF_inJRADDRESS),
    .IF_outIMEMREQ    (IF_outIMEMREQ),
    .IF_outIMEMADDR   (IF_outIMEMADDR),
    .IF_inIMEMREADY   (IF_inIMEMREADY),
    .IF_inIMEMDATA    (IF_inIMEMDATA),
    .IFID_ORDER       (IFID_ORDER),
    .IFID_PCADD4      (IFID_PCADD4),
    .IF_outBUSY       (IF_outBUSY)
  );

  always #5 CLOCK = ~CLOCK;
  assign IF_inIMEMDATA = IF_outIMEMADDR;

  logic [63:0] sb[$];
  logic [63:0] exp_v, got_v;
  int pass_cnt = 0;
  int total = 0;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (IF_outIMEMREQ !== 1'b0) $display("FAIL rst_req got %b want 0", IF_outIMEMREQ); else pass_cnt++;
    total++; if (IF_outBUSY !== 1'b0) $display("FAIL rst_busy got %b want 0", IF_outBUSY); else pass_cnt++;
    got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== 64'd0) $display("FAIL rst_ifid got %h want %h", got_v, 64'd0); else pass_cnt++;
    RESET = 1'b0;
    #1;
    total++; if (IF_outIMEMREQ !== 1'b1) $display("FAIL rst_rel_req got %b want 1", IF_outIMEMREQ); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h0) $display("FAIL rst_rel_addr got %h want 0", IF_outIMEMADDR); else pass_cnt++;
    IF_inIMEMREADY = 1'b1; IF_inPCWRITE = 1'b1; IF_inIFIDWRITE = 1'b1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      total++; if (IF_outIMEMADDR !== 32'(i*4)) $display("FAIL zw_addr[%0d] got %h want %h", i, IF_outIMEMADDR, 32'(i*4)); else pass_cnt++;
      sb.push_back({32'(i*4), 32'(i*4+4)});
      tick();
      exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
      total++; if (got_v !== exp_v) $display("FAIL zw_ifid[%0d] got %h want %h", i, got_v, exp_v); else pass_cnt++;
    end
  endtask

  task automatic test_wait_states();
    IF_inIMEMREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (IF_outIMEMADDR !== 32'h10) $display("FAIL ws_addr[%0d] got %h want 10", i, IF_outIMEMADDR); else pass_cnt++;
      sb.push_back(64'd0);
      tick();
      exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
      total++; if (got_v !== exp_v) $display("FAIL ws_bubble[%0d] got %h want %h", i, got_v, exp_v); else pass_cnt++;
    end
    IF_inIMEMREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({32'(32'h10 + i*4), 32'(32'h14 + i*4)});
      tick();
      exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
      total++; if (got_v !== exp_v) $display("FAIL ws_ifid[%0d] got %h want %h", i, got_v, exp_v); else pass_cnt++;
    end
    total++; if (IF_outIMEMADDR !== 32'h20) $display("FAIL ws_end_addr got %h want 20", IF_outIMEMADDR); else pass_cnt++;
  endtask

  task automatic test_stall();
    IF_inPCWRITE = 1'b0; IF_inIFIDWRITE = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (IF_outBUSY !== 1'b1) $display("FAIL st_busy[%0d] got %b want 1", i, IF_outBUSY); else pass_cnt++;
      total++; if (IF_outIMEMREQ !== 1'b0) $display("FAIL st_req[%0d] got %b want 0", i, IF_outIMEMREQ); else pass_cnt++;
      got_v = {IFID_ORDER, IFID_PCADD4};
      total++; if (got_v !== {32'h1C, 32'h20}) $display("FAIL st_ifid[%0d] got %h want %h", i, got_v, {32'h1C, 32'h20}); else pass_cnt++;
    end
    IF_inPCWRITE = 1'b1; IF_inIFIDWRITE = 1'b1;
    sb.push_back({32'h20, 32'h24});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL st_release got %h want %h", got_v, exp_v); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h24) $display("FAIL st_next_addr got %h want 24", IF_outIMEMADDR); else pass_cnt++;
    total++; if (IF_outBUSY !== 1'b0) $display("FAIL st_busy_clr got %b want 0", IF_outBUSY); else pass_cnt++;
  endtask

  task automatic test_redirect_pending();
    IF_inJUMP = 2'b01; IF_inJUMPADDRESS = 32'h40;
    sb.push_back(FLUSH ? 64'd0 : {32'h24, 32'h28});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL rd_jump_slot got %h want %h", got_v, exp_v); else pass_cnt++;
    IF_inJUMP = 2'b00;
    total++; if (IF_outIMEMADDR !== 32'h40) $display("FAIL rd_jump_addr got %h want 40", IF_outIMEMADDR); else pass_cnt++;
    IF_inIMEMREADY = 1'b0; IF_inPCSRC = 1'b1; IF_inBADDRESS = 32'h100;
    sb.push_back(64'd0);
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL rd_entry_bubble got %h want %h", got_v, exp_v); else pass_cnt++;
    total++; if (IF_outBUSY !== 1'b1) $display("FAIL rd_busy got %b want 1", IF_outBUSY); else pass_cnt++;
    IF_inPCSRC = 1'b0;
    tick();
    total++; if (IF_outIMEMADDR !== 32'h40) $display("FAIL rd_addr_stable got %h want 40", IF_outIMEMADDR); else pass_cnt++;
    total++; if (IF_outIMEMREQ !== 1'b1) $display("FAIL rd_req got %b want 1", IF_outIMEMREQ); else pass_cnt++;
    IF_inIMEMREADY = 1'b1;
    sb.push_back(FLUSH ? 64'd0 : {32'h40, 32'h44});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL rd_ready_data got %h want %h", got_v, exp_v); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h100) $display("FAIL rd_target_addr got %h want 100", IF_outIMEMADDR); else pass_cnt++;
    total++; if (IF_outBUSY !== 1'b0) $display("FAIL rd_busy_clr got %b want 0", IF_outBUSY); else pass_cnt++;
  endtask

  task automatic test_priority();
    IF_inRJUMP = 2'b01; IF_inJRADDRESS = 32'h200;
    IF_inJUMP = 2'b01; IF_inJUMPADDRESS = 32'h300;
    IF_inPCSRC = 1'b1; IF_inBADDRESS = 32'h400;
    sb.push_back(FLUSH ? 64'd0 : {32'h100, 32'h104});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL pr_slot got %h want %h", got_v, exp_v); else pass_cnt++;
    IF_inRJUMP = 2'b00; IF_inJUMP = 2'b00; IF_inPCSRC = 1'b0;
    total++; if (IF_outIMEMADDR !== 32'h200) $display("FAIL pr_addr got %h want 200", IF_outIMEMADDR); else pass_cnt++;
  endtask

  task automatic test_wrap();
    IF_inRJUMP = 2'b10; IF_inJRADDRESS = 32'hFFFF_FFFC;
    sb.push_back(FLUSH ? 64'd0 : {32'h200, 32'h204});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL wr_jr_slot got %h want %h", got_v, exp_v); else pass_cnt++;
    IF_inRJUMP = 2'b00;
    total++; if (IF_outIMEMADDR !== 32'hFFFF_FFFC) $display("FAIL wr_top_addr got %h want fffffffc", IF_outIMEMADDR); else pass_cnt++;
    sb.push_back({32'hFFFF_FFFC, 32'h0});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL wr_ifid got %h want %h", got_v, exp_v); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h0) $display("FAIL wr_next_addr got %h want 0", IF_outIMEMADDR); else pass_cnt++;
  endtask

  task automatic test_reset_mid_redir();
    sb.push_back({32'h0, 32'h4});
    tick();
    exp_v = sb.pop_front(); got_v = {IFID_ORDER, IFID_PCADD4};
    total++; if (got_v !== exp_v) $display("FAIL mr_pre_ifid got %h want %h", got_v, exp_v); else pass_cnt++;
    IF_inIMEMREADY = 1'b0; IF_inPCSRC = 1'b1; IF_inBADDRESS = 32'h500;
    tick();
    IF_inPCSRC = 1'b0;
    total++; if (IF_outBUSY !== 1'b1) $display("FAIL mr_busy got %b want 1", IF_outBUSY); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h4) $display("FAIL mr_addr got %h want 4", IF_outIMEMADDR); else pass_cnt++;
    #2 RESET = 1'b1;
    #1;
    total++; if (IF_outIMEMREQ !== 1'b0) $display("FAIL mr_req_drop got %b want 0", IF_outIMEMREQ); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h0) $display("FAIL mr_pc_reset got %h want 0", IF_outIMEMADDR); else pass_cnt++;
    total++; if (IF_outBUSY !== 1'b0) $display("FAIL mr_busy_clr got %b want 0", IF_outBUSY); else pass_cnt++;
    IF_inIMEMREADY = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    total++; if (IF_outIMEMREQ !== 1'b1) $display("FAIL mr_rel_req got %b want 1", IF_outIMEMREQ); else pass_cnt++;
    total++; if (IF_outIMEMADDR !== 32'h0) $display("FAIL mr_rel_addr got %h want 0", IF_outIMEMADDR); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_pending();
    test_priority();
    test_wrap();
    test_reset_mid_redir();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
